milano_dmem: RTL and testbench
==============================

Name: milano_dmem

Overview:
- Data-memory slave that sits directly downstream of the milano core's data interface.
- Consumes req/gnt/rvalid transactions from the core's load-store path and services them from a byte-enabled, word-organised on-chip RAM.
- Response latency is configurable through wait states, so the core's handshake can be exercised against slow memory.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- WAIT_CYCLES, 0, extra cycles inserted between grant and rvalid; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; subtracted from data_addr_i before indexing.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  1  request valid from core.
- data_gnt_o  out  1  request accepted; combinational.
- data_rvalid_o  out  1  one-cycle response pulse, issued for both reads and writes.
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables; bit n selects wdata[8n+7:8n].
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data; valid only while data_rvalid_o = 1.

Behaviour:
- Reset (asynchronous, rst_ni = 0):
  - FSM goes to IDLE.
  - data_rvalid_o = 0, data_rdata_o = 0, wait counter = 0.
  - data_gnt_o follows its IDLE equation (below).
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- Grant: data_gnt_o = data_req_i when state is IDLE or RESP; 0 in WAIT.
- Grant edge (rising edge with req & gnt = 1):
  - index = ((addr - BASE_ADDR) >> 2) mod DEPTH.
  - Write: each byte n with be[n] = 1 is updated; other bytes unchanged.
  - Read: the addressed word is captured into the rdata register; data_be_i is ignored for reads (full word returned).
  - Read-after-write to the same word on consecutive grants returns the new data.
- Transitions after a grant edge:
  - WAIT_CYCLES = 0: go to RESP.
  - WAIT_CYCLES > 0: go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT: counter decrements each cycle; at 0, go to RESP.
- RESP:
  - data_rvalid_o = 1 for exactly one cycle.
  - data_rdata_o = captured word for a read, 32'h0 for a write.
  - Next state: another grant in this cycle follows the grant-edge transitions; otherwise IDLE.
- Latency: rvalid asserts exactly 1+WAIT_CYCLES cycles after the grant edge.
- Throughput: with WAIT_CYCLES = 0, back-to-back requests get one grant per cycle.
- Outstanding transactions: at most one.
- Ordering: responses are in order; exactly one rvalid per grant.
- data_rdata_o holds its last value outside RESP.
- req dropped while ungranted (in WAIT): legal; no state change, no response.
- Reset asserted during WAIT or RESP: the pending response is discarded and no rvalid is issued. A write already committed at its grant edge remains in RAM.
- Address wrap: without the optional feature, indices beyond DEPTH alias modulo DEPTH.

Optional Feature:
- Macro: MILANO_DMEM_RANGE_CHK_EN.
- When defined:
  - Extra port data_err_o  out  1, reset 0.
  - A granted access with (addr - BASE_ADDR) >= DEPTH*4 (unsigned) is out of range.
  - Out-of-range access: RAM is not modified; data_err_o = 1 in the same cycle as its rvalid; data_rdata_o = 32'h0.
  - data_err_o = 0 in all other cycles.
- When undefined: no data_err_o port; out-of-range addresses alias modulo DEPTH.

Test Plan:
- Reset, then idle: data_rvalid_o = 0, data_rdata_o = 0; data_gnt_o tracks data_req_i in IDLE.
- WAIT_CYCLES = 0: write 32'hDEAD_BEEF to addr 0x10 with be = 4'hF, then read 0x10 -> gnt on each request; rvalid 1 cycle after each grant; read returns 32'hDEAD_BEEF.
- Byte enables: write 32'h1122_3344 with be = 4'hF, then 32'hAABB_CCDD with be = 4'b0101 to the same word -> read returns 32'h11BB_33DD.
- WAIT_CYCLES = 3: read -> gnt low for 3 cycles after the grant edge; rvalid exactly 4 cycles after the grant edge; a second request is held off until the RESP cycle.
- Reset pulse during WAIT after a read grant: no rvalid ever appears for that read; the next read is serviced normally.
- MILANO_DMEM_RANGE_CHK_EN defined, DEPTH = 1024: write to 0x1000 -> data_err_o = 1 with rvalid. Then read 0x0 -> data_err_o = 0 and word 0 unchanged. With the macro undefined, the same write aliases onto word 0.

Source files
------------

// File: rtl/milano_dmem.sv
// rtl/milano_dmem.sv - req/gnt/rvalid data-memory slave with byte enables and configurable wait states.
// Optional out-of-range error reporting is enabled by defining MILANO_DMEM_RANGE_CHK_EN.
module milano_dmem #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
`ifdef MILANO_DMEM_RANGE_CHK_EN
    output logic        data_err_o,
`endif
    output logic [31:0] data_rdata_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_q [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          oor;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic          unused_offset_bits;

    assign offset             = data_addr_i - BASE_ADDR;
    assign idx                = offset[AW+1:2];
    assign unused_offset_bits = ^{offset[1:0], offset[31:AW+2]};

`ifdef MILANO_DMEM_RANGE_CHK_EN
    logic err_cap_q, err_cap_d;
    assign oor = |offset[31:AW+2];
`else
    assign oor = 1'b0;
`endif

    assign data_gnt_o    = data_req_i && (state_q != S_WAIT);
    assign mem_we        = data_gnt_o && data_we_i && !oor;
    // Writes and rejected accesses respond with zero data.
    assign rd_word       = (data_we_i || oor) ? 32'h0 : mem_q[idx];
    assign data_rvalid_o = (state_q == S_RESP);
    assign data_rdata_o  = rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
`ifdef MILANO_DMEM_RANGE_CHK_EN
        err_cap_d = err_cap_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (data_gnt_o) begin
                    cap_d = rd_word;
`ifdef MILANO_DMEM_RANGE_CHK_EN
                    err_cap_d = oor;
`endif
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        // The output register only changes on entry to RESP so it holds otherwise.
        rdata_d = (state_d == S_RESP) ? cap_d : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cap_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MILANO_DMEM_RANGE_CHK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cap_q <= 1'b0;
        end else begin
            err_cap_q <= err_cap_d;
        end
    end

    assign data_err_o = (state_q == S_RESP) && err_cap_q;
`endif

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (data_be_i[n]) begin
                    mem_q[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_milano_dmem.sv
// tb/tb_milano_dmem.sv - directed self-checking bench for milano_dmem with zero and three wait states.
module tb_milano_dmem;
    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic        rv0, rv1;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
`ifdef MILANO_DMEM_RANGE_CHK_EN
    logic        err0, err1;
`endif

    int total = 0;
    int bad   = 0;

    milano_dmem #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_req_i   (req0),
        .data_gnt_o   (gnt0),
        .data_rvalid_o(rv0),
        .data_addr_i  (addr),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_wdata_i (wdata),
`ifdef MILANO_DMEM_RANGE_CHK_EN
        .data_err_o   (err0),
`endif
        .data_rdata_o (rdata0)
    );

    milano_dmem #(.DEPTH(1024), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_req_i   (req1),
        .data_gnt_o   (gnt1),
        .data_rvalid_o(rv1),
        .data_addr_i  (addr),
        .data_we_i    (we),
        .data_be_i    (be),
        .data_wdata_i (wdata),
`ifdef MILANO_DMEM_RANGE_CHK_EN
        .data_err_o   (err1),
`endif
        .data_rdata_o (rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic access(input int sel, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          output logic g, output logic [31:0] rd, output int lat,
                          output logic e);
        @(negedge clk);
        we = w; addr = a; be = b; wdata = d;
        if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
        #1;
        g = (sel == 0) ? gnt0 : gnt1;
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        lat = 1;
        while (!((sel == 0) ? rv0 : rv1) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = (sel == 0) ? rdata0 : rdata1;
`ifdef MILANO_DMEM_RANGE_CHK_EN
        e = (sel == 0) ? err0 : err1;
`else
        e = 1'b0;
`endif
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (rv0 !== 1'b0 || rdata0 !== 32'h0 || rv1 !== 1'b0 || rdata1 !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: rv0=%b rdata0=%h rv1=%b rdata1=%h want 0/0/0/0", rv0, rdata0, rv1, rdata1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        #1;
        total++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL idle_gnt_high: gnt0=%b gnt1=%b want 1/1", gnt0, gnt1);
        end
        req0 = 1'b0; req1 = 1'b0;
        #1;
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL idle_gnt_low: gnt0=%b gnt1=%b want 0/0", gnt0, gnt1);
        end
    endtask

    task automatic test_wait0;
        logic g, e; logic [31:0] rd; int lat;
        access(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, g, rd, lat, e);
        total++;
        if (g !== 1'b1 || lat != 1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL w0_write: gnt=%b lat=%0d rdata=%h want 1/1/00000000", g, lat, rd);
        end
        access(0, 1'b0, 32'h10, 4'h0, 32'h0, g, rd, lat, e);
        total++;
        if (g !== 1'b1 || lat != 1 || rd !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL w0_read: gnt=%b lat=%0d rdata=%h want 1/1/deadbeef", g, lat, rd);
        end
        @(negedge clk);
        total++;
        if (rv0 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL w0_hold: rvalid=%b rdata=%h want 0/deadbeef", rv0, rdata0);
        end
    endtask

    task automatic test_byte_enable;
        logic g, e; logic [31:0] rd; int lat;
        access(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, g, rd, lat, e);
        access(0, 1'b1, 32'h22, 4'b0101, 32'hAABB_CCDD, g, rd, lat, e);
        access(0, 1'b0, 32'h20, 4'h0, 32'h0, g, rd, lat, e);
        total++;
        if (rd !== 32'h11BB_33DD) begin
            bad++;
            $display("FAIL byte_enable: rdata=%h want 11bb33dd", rd);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        we = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'h0BAD_F00D; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0; be = 4'h0;
        #1;
        total++;
        if (rv0 !== 1'b1 || rdata0 !== 32'h0 || gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_write_resp: rvalid=%b rdata=%h gnt=%b want 1/00000000/1", rv0, rdata0, gnt0);
        end
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        total++;
        if (rv0 !== 1'b1 || rdata0 !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL b2b_read_resp: rvalid=%b rdata=%h want 1/0badf00d", rv0, rdata0);
        end
    endtask

    task automatic test_wait3;
        logic g, e; logic [31:0] rd; int lat; int hold_bad;
        access(1, 1'b1, 32'h40, 4'hF, 32'h1234_5678, g, rd, lat, e);
        total++;
        if (g !== 1'b1 || lat != 4 || rd !== 32'h0) begin
            bad++;
            $display("FAIL w3_write: gnt=%b lat=%0d rdata=%h want 1/4/00000000", g, lat, rd);
        end
        @(negedge clk);
        we = 1'b0; addr = 32'h40; be = 4'h0; req1 = 1'b1;
        @(posedge clk);
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (gnt1 !== 1'b0 || rv1 !== 1'b0) hold_bad++;
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL w3_wait_hold: bad_cycles=%0d want 0", hold_bad);
        end
        @(negedge clk);
        total++;
        if (rv1 !== 1'b1 || rdata1 !== 32'h1234_5678 || gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL w3_resp: rvalid=%b rdata=%h gnt=%b want 1/12345678/1", rv1, rdata1, gnt1);
        end
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        lat = 1;
        while (!rv1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 4 || rdata1 !== 32'h1234_5678) begin
            bad++;
            $display("FAIL w3_second: lat=%0d rdata=%h want 4/12345678", lat, rdata1);
        end
    endtask

    task automatic test_reset_in_wait;
        logic g, e; logic [31:0] rd; int lat; int spurious;
        @(negedge clk);
        we = 1'b0; addr = 32'h40; be = 4'h0; req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv1 !== 1'b0) spurious++;
        end
        total++;
        if (spurious != 0) begin
            bad++;
            $display("FAIL rst_wait_no_rvalid: rvalid_cycles=%0d want 0", spurious);
        end
        access(1, 1'b0, 32'h40, 4'h0, 32'h0, g, rd, lat, e);
        total++;
        if (g !== 1'b1 || lat != 4 || rd !== 32'h1234_5678) begin
            bad++;
            $display("FAIL rst_wait_next_read: gnt=%b lat=%0d rdata=%h want 1/4/12345678", g, lat, rd);
        end
    endtask

    task automatic test_range;
        logic g, e; logic [31:0] rd; int lat;
        access(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_0001, g, rd, lat, e);
        access(0, 1'b1, 32'h1000, 4'hF, 32'h55AA_55AA, g, rd, lat, e);
`ifdef MILANO_DMEM_RANGE_CHK_EN
        total++;
        if (e !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            bad++;
            $display("FAIL range_oor_write: err=%b rdata=%h lat=%0d want 1/00000000/1", e, rd, lat);
        end
        access(0, 1'b0, 32'h0, 4'h0, 32'h0, g, rd, lat, e);
        total++;
        if (e !== 1'b0 || rd !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL range_word0_intact: err=%b rdata=%h want 0/cafe0001", e, rd);
        end
        @(negedge clk);
        total++;
        if (err0 !== 1'b0) begin
            bad++;
            $display("FAIL range_err_idle: err=%b want 0", err0);
        end
`else
        access(0, 1'b0, 32'h0, 4'h0, 32'h0, g, rd, lat, e);
        total++;
        if (rd !== 32'h55AA_55AA) begin
            bad++;
            $display("FAIL range_alias: rdata=%h want 55aa55aa", rd);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
        test_reset();
        test_wait0();
        test_byte_enable();
        test_back_to_back();
        test_wait3();
        test_reset_in_wait();
        test_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
